// File: rtl/video_pkg.sv
// Shared constants for the video scanline stage: level encodings, default
// channel width and the pipeline latency seen by downstream consumers.
package video_pkg;

  localparam int DW_DEFAULT = 8;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_25  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_75  = 2'd3;

  localparam int VSL_LAT = 2;

endpackage

// File: rtl/scanline_dim.sv
// Combinational per-channel dimmer: truncating shifts, so the result never
// exceeds the input and no saturation is needed.
module scanline_dim
  import video_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] c,
  input  logic [1:0]    lvl,
  output logic [DW-1:0] y
);

  always_comb begin
    y = c;
    unique case (lvl)
      SL_25:   y = c - (c >> 2);
      SL_50:   y = c >> 1;
      SL_75:   y = c >> 2;
      default: y = c;
    endcase
  end

endmodule

// File: rtl/video_scanlines.sv
// CRT scanline emulation after the OSD: darkens alternate active lines with a
// frame-latched level; data and syncs share a fixed 2-cycle latency.
module video_scanlines
  import video_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter bit ODD_DARK = 1'b1
) (
  input  logic          clk_video,
  input  logic          reset_n,
  input  logic [1:0]    scanlines,
  input  logic [3*DW-1:0] din,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [3*DW-1:0] dout,
  output logic          de_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          line_par
);

  logic       de_d, vs_d;
  logic [1:0] lvl;
  logic       par;
  logic       line_end, frame_start, dim_sel;

  assign line_end    = de_d & ~de_in;
  assign frame_start = ~vs_d & vs_in;
  assign dim_sel     = (lvl != SL_OFF) && de_in && (par == ODD_DARK);

  // Frame start has priority over line end so a coincident de fall still
  // begins the new frame at parity 0.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
      lvl  <= SL_OFF;
      par  <= 1'b0;
    end else begin
      de_d <= de_in;
      vs_d <= vs_in;
      if (frame_start) begin
        lvl <= scanlines;
        par <= 1'b0;
      end else if (line_end) begin
        par <= ~par;
      end
    end
  end

  // Stage 1: capture pixel, syncs and the dim decision
  logic [3*DW-1:0] din_p1;
  logic            de_p1, hs_p1, vs_p1, dim_p1, par_p1;
  logic [1:0]      lvl_p1;

  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      din_p1 <= '0;
      de_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      dim_p1 <= 1'b0;
      par_p1 <= 1'b0;
      lvl_p1 <= SL_OFF;
    end else begin
      din_p1 <= din;
      de_p1  <= de_in;
      hs_p1  <= hs_in;
      vs_p1  <= vs_in;
      dim_p1 <= dim_sel;
      par_p1 <= par;
      lvl_p1 <= lvl;
    end
  end

  logic [3*DW-1:0] dim_px;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    scanline_dim #(.DW(DW)) u_dim (
      .c   (din_p1[ch*DW +: DW]),
      .lvl (lvl_p1),
      .y   (dim_px[ch*DW +: DW])
    );
  end

  // Stage 2: select dimmed or original pixel, align syncs and parity
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      dout     <= '0;
      de_out   <= 1'b0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      line_par <= 1'b0;
    end else begin
      dout     <= dim_p1 ? dim_px : din_p1;
      de_out   <= de_p1;
      hs_out   <= hs_p1;
      vs_out   <= vs_p1;
      line_par <= par_p1;
    end
  end

endmodule

// File: tb/tb_video_scanlines.sv
// Directed bench for video_scanlines: table of level/pixel vectors plus
// hand-written sequences for level latching, coincident edges and reset.
module tb_video_scanlines;

  logic        clk_video = 1'b0;
  logic        reset_n   = 1'b0;
  logic [1:0]  scanlines = 2'd0;
  logic [23:0] din       = '0;
  logic        de_in     = 1'b0;
  logic        hs_in     = 1'b0;
  logic        vs_in     = 1'b0;
  logic [23:0] dout;
  logic        de_out, hs_out, vs_out, line_par;

  video_scanlines dut (
    .clk_video (clk_video),
    .reset_n   (reset_n),
    .scanlines (scanlines),
    .din       (din),
    .de_in     (de_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .dout      (dout),
    .de_out    (de_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .line_par  (line_par)
  );

  always #5 clk_video = ~clk_video;

  localparam logic [23:0] BLK = 24'hA5A5A5;

  typedef struct {
    logic [23:0] px;
    logic        de, hs, vs;
    logic [23:0] exp;
    logic        par;
    bit          chk_par;
    bit          valid;
  } rec_t;

  typedef struct {
    logic [1:0]  lvl;
    logic [23:0] px;
    logic [23:0] odd_exp;
  } vec_t;

  rec_t  pend;
  vec_t  tbl [6];
  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Each call drives one input cycle and checks the output for the previous call,
  // which is exactly two clock edges old by the time it is sampled.
  task automatic cyc(input logic [23:0] px, input logic de, input logic hs, input logic vs,
                     input logic [23:0] exp, input logic par, input bit chk_par);
    din = px; de_in = de; hs_in = hs; vs_in = vs;
    @(posedge clk_video); #1;
    if (pend.valid) begin
      checks++;
      if (dout !== pend.exp || de_out !== pend.de || hs_out !== pend.hs ||
          vs_out !== pend.vs || (pend.chk_par && line_par !== pend.par)) begin
        failures++;
        $display("FAIL %s: got dout=%h de=%b hs=%b vs=%b par=%b, want dout=%h de=%b hs=%b vs=%b par=%b(chk=%0d)",
                 phase, dout, de_out, hs_out, vs_out, line_par,
                 pend.exp, pend.de, pend.hs, pend.vs, pend.par, pend.chk_par);
      end
    end
    pend.px = px; pend.de = de; pend.hs = hs; pend.vs = vs;
    pend.exp = exp; pend.par = par; pend.chk_par = chk_par; pend.valid = 1'b1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (dout !== '0 || de_out !== 1'b0 || hs_out !== 1'b0 || vs_out !== 1'b0 || line_par !== 1'b0) begin
      failures++;
      $display("FAIL %s: got dout=%h de=%b hs=%b vs=%b par=%b, want all zero",
               name, dout, de_out, hs_out, vs_out, line_par);
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(BLK, 1'b0, (i < n - 1), 1'b0, BLK, 1'b0, 1'b0);
  endtask

  task automatic vsync();
    cyc(BLK, 1'b0, 1'b0, 1'b1, BLK, 1'b0, 1'b0);
    cyc(BLK, 1'b0, 1'b0, 1'b1, BLK, 1'b0, 1'b0);
    cyc(BLK, 1'b0, 1'b0, 1'b0, BLK, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nl, input int nw, input bit ramp, input logic [23:0] pc,
                       input logic [23:0] odd_exp, input bit odd_dim,
                       input int chg_line, input logic [1:0] chg_lvl);
    logic [23:0] px, e;
    vsync();
    for (int k = 0; k < nl; k++) begin
      if (k == chg_line) scanlines = chg_lvl;
      for (int x = 0; x < nw; x++) begin
        px = ramp ? {8'(k), 8'(x), 8'(k * 16 + x + 1)} : pc;
        e  = (odd_dim && k[0]) ? odd_exp : px;
        cyc(px, 1'b1, 1'b0, 1'b0, e, k[0], 1'b1);
      end
      blank(3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'd2, 24'hFF8040, 24'h7F4020};
    tbl[1] = '{2'd1, 24'h808080, 24'h606060};
    tbl[2] = '{2'd3, 24'h808080, 24'h202020};
    tbl[3] = '{2'd1, 24'hFF8040, 24'hC06030};
    tbl[4] = '{2'd3, 24'hFF8040, 24'h3F2010};
    tbl[5] = '{2'd0, 24'h123456, 24'h123456};
    pend.valid = 1'b0;

    repeat (3) @(posedge clk_video);
    #1;
    check_zero("reset_state");
    reset_n = 1'b1;

    phase = "passthrough";
    for (int f = 0; f < 4; f++) frame(8, 16, 1'b1, '0, '0, 1'b0, -1, 2'd0);

    for (int i = 0; i < 6; i++) begin
      phase = $sformatf("dim_vec%0d", i);
      scanlines = tbl[i].lvl;
      frame(4, 6, 1'b0, tbl[i].px, tbl[i].odd_exp, 1'b1, -1, 2'd0);
    end

    phase = "midframe_ignored";
    scanlines = 2'd0;
    frame(6, 6, 1'b0, 24'h808080, '0, 1'b0, 3, 2'd3);
    phase = "midframe_next";
    frame(4, 6, 1'b0, 24'h808080, 24'h202020, 1'b1, -1, 2'd0);

    phase = "vs_and_de_fall";
    scanlines = 2'd2;
    vsync();
    repeat (4) cyc(24'hFF8040, 1'b1, 1'b0, 1'b0, 24'hFF8040, 1'b0, 1'b1);
    cyc(BLK, 1'b0, 1'b0, 1'b1, BLK, 1'b0, 1'b0);
    cyc(BLK, 1'b0, 1'b0, 1'b1, BLK, 1'b0, 1'b0);
    cyc(BLK, 1'b0, 1'b0, 1'b0, BLK, 1'b0, 1'b0);
    repeat (4) cyc(24'hFF8040, 1'b1, 1'b0, 1'b0, 24'hFF8040, 1'b0, 1'b1);
    blank(2);
    repeat (4) cyc(24'hFF8040, 1'b1, 1'b0, 1'b0, 24'h7F4020, 1'b1, 1'b1);
    blank(2);

    phase = "reset_midline";
    scanlines = 2'd3;
    vsync();
    repeat (4) cyc(24'h808080, 1'b1, 1'b0, 1'b0, 24'h808080, 1'b0, 1'b1);
    blank(2);
    repeat (3) cyc(24'h808080, 1'b1, 1'b0, 1'b0, 24'h202020, 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    check_zero("reset_assert");
    pend.valid = 1'b0;
    repeat (3) begin
      @(posedge clk_video); #1;
      check_zero("reset_hold");
    end
    reset_n = 1'b1;
    phase = "after_reset";
    repeat (3) cyc(24'h808080, 1'b1, 1'b0, 1'b0, 24'h808080, 1'b0, 1'b1);
    blank(2);
    repeat (4) cyc(24'h808080, 1'b1, 1'b0, 1'b0, 24'h808080, 1'b1, 1'b1);
    blank(2);
    phase = "after_reset_vs";
    frame(4, 6, 1'b0, 24'h808080, 24'h202020, 1'b1, -1, 2'd0);
    blank(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_scanlines.md
Name: video_scanlines

Overview:
- Post-OSD video stage: consumes the OSD block's dout/de_out/hs_out/vs_out and darkens alternate active lines to emulate CRT scanlines.
- Runs on the video clock at full rate, with no pixel enable.
- The dimming level is software-selected and takes effect only on a frame boundary, so a frame is never torn.
- Output goes to the scaler/VGA pins with a fixed, matched delay on data and sync.

Parameters:
- DW, 8, bits per colour channel; pixel bus is 3*DW, ordered R[23:16] G[15:8] B[7:0] at default.
- ODD_DARK, 1, 1 = darken lines with parity 1; 0 = darken parity 0.

Ports:
- clk_video  in  1  video clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- scanlines  in  2  level select: 0 off, 1 = 25% dim, 2 = 50% dim, 3 = 75% dim.
- din  in  3*DW  pixel in (from OSD dout).
- de_in  in  1  active video.
- hs_in  in  1  hsync, pass-through only.
- vs_in  in  1  vsync, active-high.
- dout  out  3*DW  pixel out.
- de_out  out  1  delayed de_in.
- hs_out  out  1  delayed hs_in.
- vs_out  out  1  delayed vs_in.
- line_par  out  1  current line parity, for debug/verification.

Behaviour:
- Interface: one clock, clk_video. Reset is asynchronous and active-low via reset_n.
- Reset values: all outputs 0; parity 0; latched level 0; edge-detect registers 0.
- Edge detection: registered copies de_d and vs_d.
  - Line end: de_d & ~de_in.
  - Frame start: ~vs_d & vs_in.
- Level latch:
  - On frame start, lvl <= scanlines.
  - scanlines changes mid-frame are ignored until the next vs rise.
- Parity counter:
  - Frame start: par <= 0.
  - Line end (no frame start in the same cycle): par <= ~par.
  - Frame start and line end in the same cycle: frame start wins, par = 0.
  - par updates at line end, so it is stable for the whole next active line.
- Dim rule, per channel c (DW bits, unsigned, no rounding):
  - lvl 1: c - (c>>2).
  - lvl 2: c>>1.
  - lvl 3: c>>2.
  - lvl 0: c.
  - Results never exceed c; no saturation logic is needed.
- Selection: pixel is dimmed iff lvl != 0, de_in = 1, and par == ODD_DARK. Otherwise din passes through bit-exact.
- Blanking: when de_in = 0, din passes through unchanged. Blanking data is not forced to zero; upstream already blanks it.
- Pipeline, 2 clk_video stages:
  - S1: register din, de/hs/vs, and the dim-select flag; compute the three shifted variants.
  - S2: mux to dout; register the delayed syncs.
  - dout, de_out, hs_out and vs_out all have latency exactly 2 relative to inputs; skew between them is 0.
- line_par: par delayed to align with dout (latency 2).
- Reset mid-frame: outputs go to 0 immediately.
  - After release, lvl stays 0, so the block is a 2-cycle passthrough until the first vs rise.
  - Parity restarts at 0.
- Interlace: parity resets every field, so both fields darken the same line numbers. This is accepted.

Decomposition:
- Package video_pkg:
  - localparams SL_OFF = 2'd0, SL_25 = 2'd1, SL_50 = 2'd2, SL_75 = 2'd3.
  - default DW.
  - pipeline latency constant VSL_LAT = 2, for the bench's expected-data model.
- Sub-module scanline_dim: purely combinational per channel, (c, lvl) -> dimmed c; instantiated 3x.
- Top level holds the edge detection, parity, level latch and pipeline.

Test Plan:
- Passthrough: reset, scanlines = 0, 4 frames of 640x480 ramp -> dout == din delayed by exactly 2 clocks on every pixel; de/hs/vs delayed by 2.
- 50% level: scanlines = 2 before vs rise, din = 24'hFF8040 -> even lines 24'hFF8040, odd lines 24'h7F4020.
- 25% and 75% levels: din = 24'h808080 -> odd lines 24'h606060 at lvl 1, 24'h202020 at lvl 3.
- Mid-frame change: switch scanlines 0->3 at line 100 -> no dimming until the next vs rise; the following frame's line 1 is dimmed.
- Simultaneous frame start and line end: vs rise in the same cycle as a de fall -> line_par = 0 for the first line; the next line is parity 1.
- Async reset mid-line: pulse reset_n low for 3 cycles with de high -> all outputs 0 in the same cycle reset_n falls; after release, pure passthrough until the next vs rise; no X on outputs.
